// File: rtl/hog_cell_hist.sv
// hog_cell_hist: 9-bin unsigned-orientation HOG histogram per CELLxCELL cell.
// Optional macro HOG_MAG_CLIP_EN clips magnitude to MAG_CLIP before accumulation.
module hog_cell_hist #(
   parameter int PIX_W    = 8,
   parameter int MAG_F    = 4,
   parameter int TAN_I    = 4,
   parameter int TAN_F    = 16,
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int CELL     = 8,
   parameter int MAG_CLIP = 4095,
   localparam int MAG_W   = PIX_W + 1 + MAG_F,
   localparam int TAN_W   = TAN_I + TAN_F,
   localparam int LC      = $clog2(CELL),
   localparam int HIST_W  = MAG_W + 2 * LC,
   localparam int NCX     = IMG_W / CELL,
   localparam int NCY     = IMG_H / CELL,
   localparam int CXW     = (NCX > 1) ? $clog2(NCX) : 1,
   localparam int CYW     = (NCY > 1) ? $clog2(NCY) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic [MAG_W-1:0]      magnitude,
   input  logic [TAN_W-1:0]      tan,
   output logic [9*HIST_W-1:0]   hist,
   output logic [CXW-1:0]        cell_x,
   output logic [CYW-1:0]        cell_y,
   output logic                  o_valid,
   output logic                  o_last
);

   localparam int COLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROWW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int AW   = TAN_W + 1;

   localparam logic [COLW-1:0] COL_MAX = COLW'(IMG_W - 1);
   localparam logic [ROWW-1:0] ROW_MAX = ROWW'(IMG_H - 1);

   // orientation thresholds: tan(20/40/60/80 deg) in TAN_F fraction units
   localparam logic [AW-1:0] T20 = AW'(23853);
   localparam logic [AW-1:0] T40 = AW'(54991);
   localparam logic [AW-1:0] T60 = AW'(113512);
   localparam logic [AW-1:0] T80 = AW'(371673);

`ifdef HOG_MAG_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif
   localparam logic [MAG_W-1:0] CLIP_V = MAG_W'(MAG_CLIP);

   logic [COLW-1:0]      r_col;
   logic [ROWW-1:0]      r_row;

   logic                 w_neg;
   logic [AW-1:0]        w_tx;
   logic [AW-1:0]        w_abs;
   logic [3:0]           w_bin;
   logic [MAG_W-1:0]     w_mag;
   logic                 w_done;
   logic                 w_last;
   logic [CXW-1:0]       w_idx;
   logic [CYW-1:0]       w_cy;

   logic                 r1_valid;
   logic [3:0]           r1_bin;
   logic [MAG_W-1:0]     r1_mag;
   logic [CXW-1:0]       r1_idx;
   logic [CYW-1:0]       r1_cy;
   logic                 r1_done;
   logic                 r1_last;

   logic [9*HIST_W-1:0]  r_store [NCX];
   logic [9*HIST_W-1:0]  w_rd;
   logic [9*HIST_W-1:0]  w_sum;

   // raster position of the next accepted sample
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_valid) begin
         if (r_col == COL_MAX) begin
            r_col <= '0;
            if (r_row == ROW_MAX)
               r_row <= '0;
            else
               r_row <= r_row + ROWW'(1);
         end else begin
            r_col <= r_col + COLW'(1);
         end
      end
   end

   // cell membership and completion of the current sample
   always_comb begin
      w_done = (r_row[LC-1:0] == {LC{1'b1}})
            && (r_col[LC-1:0] == {LC{1'b1}});
      w_last = w_done && (r_row == ROW_MAX) && (r_col == COL_MAX);
      w_idx  = CXW'(r_col >> LC);
      w_cy   = CYW'(r_row >> LC);
   end

   // |tan| at one extra bit so the most-negative code cannot overflow
   always_comb begin
      w_neg = tan[TAN_W-1];
      w_tx  = {tan[TAN_W-1], tan};
      w_abs = w_neg ? (~w_tx + AW'(1)) : w_tx;
   end

   // quantise the angle into one of nine 20-degree bins
   always_comb begin
      w_bin = 4'd0;
      if (!w_neg) begin
         if (w_abs < T20)      w_bin = 4'd0;
         else if (w_abs < T40) w_bin = 4'd1;
         else if (w_abs < T60) w_bin = 4'd2;
         else if (w_abs < T80) w_bin = 4'd3;
         else                  w_bin = 4'd4;
      end else begin
         if (w_abs > T80)      w_bin = 4'd4;
         else if (w_abs > T60) w_bin = 4'd5;
         else if (w_abs > T40) w_bin = 4'd6;
         else if (w_abs > T20) w_bin = 4'd7;
         else                  w_bin = 4'd8;
      end
   end

   // optional magnitude ceiling to suppress dominant edges
   always_comb begin
      w_mag = magnitude;
      if (CLIP_EN && (magnitude > CLIP_V))
         w_mag = CLIP_V;
   end

   // S1: register bin, magnitude, entry index and completion flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_bin   <= '0;
         r1_mag   <= '0;
         r1_idx   <= '0;
         r1_cy    <= '0;
         r1_done  <= 1'b0;
         r1_last  <= 1'b0;
      end else begin
         r1_valid <= i_valid;
         if (i_valid) begin
            r1_bin  <= w_bin;
            r1_mag  <= w_mag;
            r1_idx  <= w_idx;
            r1_cy   <= w_cy;
            r1_done <= w_done;
            r1_last <= w_last;
         end
      end
   end

   // S2 read side: entry contents plus this sample's contribution
   always_comb begin
      w_rd  = r_store[r1_idx];
      w_sum = '0;
      for (int k = 0; k < 9; k++) begin
         w_sum[k*HIST_W +: HIST_W] = w_rd[k*HIST_W +: HIST_W]
            + ((r1_bin == 4'(k)) ? HIST_W'(r1_mag) : HIST_W'(0));
      end
   end

   // S2 write side: accumulate, or clear the entry when its cell completes
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int e = 0; e < NCX; e++)
            r_store[e] <= '0;
      end else if (r1_valid) begin
         r_store[r1_idx] <= r1_done ? '0 : w_sum;
      end
   end

   // S2 outputs: strobe a finished cell, otherwise hold the last one
   always_ff @(posedge clk) begin
      if (rst) begin
         hist    <= '0;
         cell_x  <= '0;
         cell_y  <= '0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
      end else begin
         o_valid <= r1_valid & r1_done;
         o_last  <= r1_valid & r1_done & r1_last;
         if (r1_valid && r1_done) begin
            hist   <= w_sum;
            cell_x <= r1_idx;
            cell_y <= r1_cy;
         end
      end
   end

endmodule

// File: tb/tb_hog_cell_hist.sv
// tb_hog_cell_hist: random and directed frames against a cell-sum model.
// Cell histograms are predicted from angle thresholds and raster position.
module tb_hog_cell_hist;

   localparam int IMG  = 16;
   localparam int CELL = 8;
   localparam int NC   = IMG / CELL;
   localparam int HW   = 19;
   localparam int CLIP = 100;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i_valid = 1'b0;
   logic [12:0]     magnitude = '0;
   logic [19:0]     tan = '0;
   logic [9*HW-1:0] hist;
   logic [0:0]      cell_x;
   logic [0:0]      cell_y;
   logic            o_valid;
   logic            o_last;

   hog_cell_hist #(
      .IMG_W    (IMG),
      .IMG_H    (IMG),
      .CELL     (CELL),
      .MAG_CLIP (CLIP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .magnitude (magnitude),
      .tan       (tan),
      .hist      (hist),
      .cell_x    (cell_x),
      .cell_y    (cell_y),
      .o_valid   (o_valid),
      .o_last    (o_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9*HW-1:0] h;
      int              cx;
      int              cy;
      bit              last;
      int              due;
   } exp_t;

   exp_t            q[$];
   int              cellsum [NC][NC][9];
   int              mrow = 0;
   int              mcol = 0;
   int              cyc = 0;
   int              n_chk = 0;
   int              n_pass = 0;
   bit              mon_on = 0;
   logic [9*HW-1:0] last_h = '0;
   int              bv [8] = '{23852, 23853, 371673, -371673,
                              -371674, -23853, -23854, 524288};

   task automatic check(input string tag, input logic [191:0] got,
                        input logic [191:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // bin = how many orientation thresholds the angle has passed
   function automatic int ref_bin(input logic [19:0] tv);
      int th [4];
      int t;
      int a;
      int n;
      th = '{23853, 54991, 113512, 371673};
      t = int'($signed(tv));
      n = 0;
      if (t >= 0) begin
         for (int i = 0; i < 4; i++) if (t >= th[i]) n++;
         return n;
      end
      a = -t;
      for (int i = 0; i < 4; i++) if (a > th[i]) n++;
      return 8 - n;
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   task automatic clear_model();
      q.delete();
      mrow = 0;
      mcol = 0;
      for (int y = 0; y < NC; y++)
         for (int x = 0; x < NC; x++)
            for (int k = 0; k < 9; k++) cellsum[y][x][k] = 0;
   endtask

   task automatic send(input int m, input logic [19:0] tv);
      int b;
      int e;
      int cx;
      int cy;
      @(posedge clk); #1;
      i_valid = 1'b1;
      magnitude = 13'(m);
      tan = tv;
      b = ref_bin(tv);
      e = m;
`ifdef HOG_MAG_CLIP_EN
      if (e > CLIP) e = CLIP;
`endif
      cx = mcol / CELL;
      cy = mrow / CELL;
      cellsum[cy][cx][b] += e;
      if (mrow % CELL == CELL - 1 && mcol % CELL == CELL - 1) begin
         exp_t x;
         x.h = '0;
         for (int k = 0; k < 9; k++) begin
            x.h[k*HW +: HW] = HW'(cellsum[cy][cx][k]);
            cellsum[cy][cx][k] = 0;
         end
         x.cx = cx;
         x.cy = cy;
         x.last = (mrow == IMG - 1) && (mcol == IMG - 1);
         x.due = cyc + 2;
         q.push_back(x);
      end
      mcol++;
      if (mcol == IMG) begin
         mcol = 0;
         mrow++;
         if (mrow == IMG) mrow = 0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         i_valid = 1'b0;
         magnitude = 13'($urandom);
         tan = 20'($urandom);
      end
   endtask

   task automatic do_reset();
      idle(3);
      @(posedge clk); #1;
      mon_on = 0;
      rst = 1'b1;
      i_valid = 1'b0;
      clear_model();
      @(posedge clk);
      @(negedge clk);
      check("rst_hist", hist, 0);
      check("rst_cx", cell_x, 0);
      check("rst_cy", cell_y, 0);
      check("rst_ovalid", o_valid, 0);
      check("rst_olast", o_last, 0);
      last_h = '0;
      rst = 1'b0;
      @(posedge clk); #1;
      mon_on = 1;
   endtask

   // compare every strobe, its timing, and the held value between strobes
   always @(negedge clk) begin
      bit due;
      if (mon_on) begin
         if (q.size() > 0 && q[0].due < cyc) begin
            check("late", 0, 1);
            void'(q.pop_front());
         end
         due = (q.size() > 0) && (q[0].due == cyc);
         if (o_valid || due) begin
            check("strobe", o_valid, due);
            if (due) begin
               check("hist", hist, q[0].h);
               check("cell_x", cell_x, q[0].cx);
               check("cell_y", cell_y, q[0].cy);
               check("o_last", o_last, q[0].last);
               last_h = q[0].h;
               void'(q.pop_front());
            end
         end else if (cyc % 8 == 0) begin
            check("hold", hist, last_h);
            check("idle_last", o_last, 0);
         end
      end
   end

   task automatic frame_const(input int m, input int gap);
      for (int p = 0; p < IMG * IMG; p++) begin
         send(m, 20'(0));
         if (gap > 0) idle(gap);
      end
   endtask

   initial begin
      clear_model();
      do_reset();

      // one boundary tan value per cell, two frames
      for (int f = 0; f < 2; f++)
         for (int p = 0; p < IMG * IMG; p++) begin
            int r;
            int c;
            r = p / IMG;
            c = p % IMG;
            send(1, 20'(bv[f*4 + (r/CELL)*2 + c/CELL]));
         end

      frame_const(16, 0);
      frame_const(3, 0);
      frame_const(16, 2);
      frame_const(8191, 0);

      for (int p = 0; p < 100; p++) send(16, 20'(0));
      do_reset();
      frame_const(16, 0);

      for (int f = 0; f < 3; f++)
         for (int p = 0; p < IMG * IMG; p++) begin
            logic [19:0] tv;
            if ($urandom_range(0, 3) == 0) tv = 20'(bv[$urandom_range(0, 7)]);
            else tv = 20'($urandom);
            send($urandom_range(0, 8191), tv);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         end

      idle(6);
      check("drain", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
